muldiv_seq: RTL
===============

# muldiv_seq

Iterative multiply/divide sequencer for the EX stage. It runs MULT/DIV instructions by borrowing the shared ALU for WORD_LEN consecutive cycles: shift-add for multiply, restoring subtract for divide. While it works it asserts a pipeline stall and owns the ALU input muxes. Results land in HI/LO registers that the writeback and forwarding paths read.

## Interface
- WORD_LEN, 32, operand, ALU and HI/LO width
- EXE_CMD_LEN, 4, width of ALU command; must match the shared ALU
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request from EX; sampled only in IDLE or DONE
- op  in  2  op[0]: 0=multiply, 1=divide; op[1]: 1=signed (used only with MULDIV_SIGNED_EN)
- src_a, src_b  in  WORD_LEN  multiplicand/dividend, multiplier/divisor
- alu_result  in  WORD_LEN  shared ALU output (aluOut)
- alu_own  out  1  1 = EX mux routes alu_a/alu_b/alu_cmd into the ALU
- alu_a, alu_b  out  WORD_LEN  ALU operands
- alu_cmd  out  EXE_CMD_LEN  EXE_ADD (multiply) or EXE_SUB (divide)
- stall  out  1  freeze IF/ID/EX
- done  out  1  one-cycle pulse; HI/LO valid
- hi, lo  out  WORD_LEN  product high/low; or remainder (hi) and quotient (lo)
- div_zero  out  1  sticky until next accepted start; divisor was 0

## Operation
- States: IDLE, RUN, DONE. Counter cnt: log2(WORD_LEN) bits.
- IDLE, start=1: latch operands, cnt=0, clear div_zero.
  - Divide with src_b=0: go to DONE, hi=src_a, lo=all ones, div_zero=1.
  - Otherwise go to RUN.
- RUN multiply: acc{hi,lo} is loaded as {0, src_b}; M=src_a.
  - Each cycle drive alu_a=hi, alu_b=(lo[0] ? M : 0), alu_cmd=EXE_ADD.
  - carry = (alu_result < hi) unsigned.
  - Update {hi,lo} <= {carry, alu_result, lo} >> 1.
- RUN divide: rem=hi=0, quotient shift reg=lo=src_a, D=src_b.
  - Shift {msb, rem_sh} = {hi, lo[WORD_LEN-1]}.
  - Drive alu_a=rem_sh, alu_b=D, alu_cmd=EXE_SUB.
  - take = msb | (alu_result <= rem_sh).
  - hi <= take ? alu_result : rem_sh; lo <= {lo[WORD_LEN-2:0], take}.
- After the RUN cycle with cnt=WORD_LEN-1, go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back).
  - Otherwise go to IDLE.
- start in RUN is ignored; EX holds the instruction via stall.
- hi/lo hold their values in IDLE until the next accepted start.
- Outside RUN: alu_own=0, alu_a=alu_b=0, alu_cmd=EXE_ADD.

## Timing
- Reset values: state=IDLE, cnt=0, hi=lo=0, done=0, stall=0, alu_own=0, div_zero=0, alu_a=alu_b=0.
- rst overrides everything, including mid-RUN: state is IDLE and all outputs are at reset values in the cycle after the reset edge.
- stall is combinational: stall = (IDLE|DONE)&start | RUN. It is high in the accept cycle and all RUN cycles, and low in DONE.
- alu_own = RUN. ALU is combinational, so alu_result is consumed in the same cycle.
- Latency: start sampled at edge t0, RUN spans cycles t0+1..t0+WORD_LEN, done is high in cycle t0+WORD_LEN+1. Divide-by-zero: done in cycle t0+1.

## Configuration
- MULDIV_SIGNED_EN defined:
  - With op[1]=1, latch |src_a| and |src_b|; negation is computed locally, not on the ALU.
  - On entry to DONE, negate the product if signs differ.
  - For divide: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Latency is unchanged.
- Undefined: op[1] is ignored; all operations are unsigned.

## Structure
- Add to the shared defines file: MD_OP_MUL, MD_OP_DIV, MD_OP_SIGNED_BIT, and state encodings MD_IDLE/MD_RUN/MD_DONE. Reuse the existing EXE_ADD/EXE_SUB and WORD_LEN/EXE_CMD_LEN.
- One sub-module, muldiv_step: combinational next-{hi,lo} and ALU-operand selection from mode/hi/lo/alu_result. The FSM, counter and sign fixup stay in muldiv_seq.

## Test plan
- Multiply unsigned 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done at t0+33, stall high t0..t0+32.
- Divide unsigned 100/7 → lo=14, hi=2, div_zero=0; alu_cmd=EXE_SUB and alu_own=1 during all 32 RUN cycles.
- Divide 0x1234/0 → done at t0+1, hi=0x1234, lo=0xFFFFFFFF, div_zero=1; next valid start clears div_zero.
- Assert rst at RUN cycle 10 of 7*6 → next cycle IDLE, hi=lo=0, stall=0, alu_own=0, no done pulse.
- Hold start through RUN → no restart; start in the DONE cycle → second op (7*6) accepted, lo=42, done exactly 33 cycles later.
- With MULDIV_SIGNED_EN: signed -7*3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; signed -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared EX-stage definitions for the iterative multiply/divide sequencer.
// Command encodings must match the shared ALU.
package muldiv_seq_pkg;

  localparam int WORD_LEN    = 32;
  localparam int EXE_CMD_LEN = 4;
  localparam int CNT_W       = $clog2(WORD_LEN);

  localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'b0000;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'b0010;

  localparam logic MD_OP_MUL        = 1'b0;
  localparam logic MD_OP_DIV        = 1'b1;
  localparam int   MD_OP_SIGNED_BIT = 1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic [WORD_LEN-1:0] neg_word(input logic [WORD_LEN-1:0] v);
    return ~v + WORD_LEN'(1);
  endfunction

  function automatic logic [WORD_LEN-1:0] abs_word(input logic [WORD_LEN-1:0] v);
    return v[WORD_LEN-1] ? neg_word(v) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply / restoring divide: ALU operand
// selection and next {hi,lo} from the ALU result.
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic                   div_i,
  input  logic [WORD_LEN-1:0]    hi_i,
  input  logic [WORD_LEN-1:0]    lo_i,
  input  logic [WORD_LEN-1:0]    opnd_i,
  input  logic [WORD_LEN-1:0]    alu_result_i,
  output logic [WORD_LEN-1:0]    alu_a_o,
  output logic [WORD_LEN-1:0]    alu_b_o,
  output logic [EXE_CMD_LEN-1:0] alu_cmd_o,
  output logic [WORD_LEN-1:0]    hi_o,
  output logic [WORD_LEN-1:0]    lo_o
);

  logic [WORD_LEN-1:0] rem_sh_s;
  logic                take_s;
  logic                carry_s;

  assign rem_sh_s = {hi_i[WORD_LEN-2:0], lo_i[WORD_LEN-1]};

  // ALU operand selection; kept apart from the result path to avoid a false loop
  always_comb begin
    if (div_i) begin
      alu_a_o   = rem_sh_s;
      alu_b_o   = opnd_i;
      alu_cmd_o = EXE_SUB;
    end else begin
      alu_a_o   = hi_i;
      alu_b_o   = lo_i[0] ? opnd_i : '0;
      alu_cmd_o = EXE_ADD;
    end
  end

  // Next accumulator; the shifted-out remainder MSB forces a subtract
  always_comb begin
    take_s  = 1'b0;
    carry_s = 1'b0;
    if (div_i) begin
      take_s = hi_i[WORD_LEN-1] | (alu_result_i <= rem_sh_s);
      hi_o   = take_s ? alu_result_i : rem_sh_s;
      lo_o   = {lo_i[WORD_LEN-2:0], take_s};
    end else begin
      carry_s = (alu_result_i < hi_i);
      hi_o    = {carry_s, alu_result_i[WORD_LEN-1:1]};
      lo_o    = {alu_result_i[0], lo_i[WORD_LEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/DIV sequencer borrowing the shared EX ALU for WORD_LEN cycles.
// Optional signed support: define MULDIV_SIGNED_EN.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [1:0]             op_i,
  input  logic [WORD_LEN-1:0]    src_a_i,
  input  logic [WORD_LEN-1:0]    src_b_i,
  input  logic [WORD_LEN-1:0]    alu_result_i,
  output logic                   alu_own_o,
  output logic [WORD_LEN-1:0]    alu_a_o,
  output logic [WORD_LEN-1:0]    alu_b_o,
  output logic [EXE_CMD_LEN-1:0] alu_cmd_o,
  output logic                   stall_o,
  output logic                   done_o,
  output logic [WORD_LEN-1:0]    hi_o,
  output logic [WORD_LEN-1:0]    lo_o,
  output logic                   div_zero_o
);

  md_state_e           state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORD_LEN-1:0] hi_q, lo_q, opnd_q;
  logic                div_q, done_q, div_zero_q;

  logic [WORD_LEN-1:0]    a_in_s, b_in_s, hi_d, lo_d;
  logic [WORD_LEN-1:0]    step_a_s, step_b_s, step_hi_s, step_lo_s;
  logic [EXE_CMD_LEN-1:0] step_cmd_s;
  logic                   run_s, last_s;

`ifdef MULDIV_SIGNED_EN
  logic                    neg_main_q, neg_rem_q, sgn_s;
  logic [2*WORD_LEN-1:0]   prod_neg_s;
`else
  logic                    unused_sign_s;
  assign unused_sign_s = op_i[MD_OP_SIGNED_BIT];
`endif

  muldiv_step u_step (
    .div_i        (div_q),
    .hi_i         (hi_q),
    .lo_i         (lo_q),
    .opnd_i       (opnd_q),
    .alu_result_i (alu_result_i),
    .alu_a_o      (step_a_s),
    .alu_b_o      (step_b_s),
    .alu_cmd_o    (step_cmd_s),
    .hi_o         (step_hi_s),
    .lo_o         (step_lo_s)
  );

  assign run_s     = (state_q == MD_RUN);
  assign last_s    = (cnt_q == CNT_W'(WORD_LEN - 1));
  assign alu_own_o = run_s;
  assign alu_a_o   = run_s ? step_a_s : '0;
  assign alu_b_o   = run_s ? step_b_s : '0;
  assign alu_cmd_o = run_s ? step_cmd_s : EXE_ADD;
  assign stall_o   = run_s | (((state_q == MD_IDLE) | (state_q == MD_DONE)) & start_i);
  assign done_o    = done_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign div_zero_o = div_zero_q;

  // Operand magnitudes to latch on accept
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sgn_s = op_i[MD_OP_SIGNED_BIT];
    if (sgn_s) begin
      a_in_s = abs_word(src_a_i);
      b_in_s = abs_word(src_b_i);
    end else begin
      a_in_s = src_a_i;
      b_in_s = src_b_i;
    end
`else
    a_in_s = src_a_i;
    b_in_s = src_b_i;
`endif
  end

  // Step result, with sign fixup folded into the final RUN cycle
  always_comb begin
    hi_d = step_hi_s;
    lo_d = step_lo_s;
`ifdef MULDIV_SIGNED_EN
    prod_neg_s = ~{step_hi_s, step_lo_s} + (2*WORD_LEN)'(1);
    if (last_s && div_q) begin
      lo_d = neg_main_q ? neg_word(step_lo_s) : step_lo_s;
      hi_d = neg_rem_q ? neg_word(step_hi_s) : step_hi_s;
    end else if (last_s && neg_main_q) begin
      hi_d = prod_neg_s[2*WORD_LEN-1:WORD_LEN];
      lo_d = prod_neg_s[WORD_LEN-1:0];
    end else begin
      hi_d = step_hi_s;
      lo_d = step_lo_s;
    end
`endif
  end

  // Sequencer FSM, iteration counter and HI/LO state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      div_q      <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        MD_IDLE, MD_DONE: begin
          if (start_i) begin
            cnt_q      <= '0;
            div_q      <= (op_i[0] == MD_OP_DIV);
            div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_main_q <= sgn_s & (src_a_i[WORD_LEN-1] ^ src_b_i[WORD_LEN-1]);
            neg_rem_q  <= sgn_s & src_a_i[WORD_LEN-1];
`endif
            if ((op_i[0] == MD_OP_DIV) && (src_b_i == '0)) begin
              state_q    <= MD_DONE;
              done_q     <= 1'b1;
              hi_q       <= src_a_i;
              lo_q       <= {WORD_LEN{1'b1}};
              div_zero_q <= 1'b1;
            end else begin
              state_q <= MD_RUN;
              done_q  <= 1'b0;
              hi_q    <= '0;
              lo_q    <= (op_i[0] == MD_OP_DIV) ? a_in_s : b_in_s;
              opnd_q  <= (op_i[0] == MD_OP_DIV) ? b_in_s : a_in_s;
            end
          end else begin
            state_q <= MD_IDLE;
            done_q  <= 1'b0;
          end
        end
        MD_RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_s) begin
            state_q <= MD_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= MD_RUN;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
